// File: rtl/note_sequence_ctrl.sv
// note_sequence_ctrl
// Sequences the music note detector and turns its raw note_out into a
// melody event stream. On start, and again after every silence, it pulses
// the detector reset. It accepts a note only after the note has been seen
// on several consecutive waveform edges. It measures each note's length in
// waveform edges and queues note and silence events in a small FIFO.
//
// Ports
//   clk, reset          50 MHz clock, asynchronous active-high reset
//   waveform            raw square wave (asynchronous, synchronised here)
//   det_note[2:0]       detector note_out (0=Sa .. 7=high Sa)
//   det_reset           detector reset, high ARM_CYC cycles while arming
//   start, stop         one-cycle capture control pulses
//   busy                high whenever the controller is not idle
//   evt_valid/evt_ready event stream handshake
//   evt_note, evt_silence, evt_dur   head event fields (zero when empty)
//   overflow            sticky; an event was dropped because the FIFO was full
//   state_dbg[2:0]      current controller state, for observation
//
// Handshake: the head event is transferred on every clock edge where
// evt_valid and evt_ready are both high. evt_valid never depends on
// evt_ready. While evt_valid is high and evt_ready is low, the head event
// holds its value.
module note_sequence_ctrl #(
  parameter int STABLE_EDGES = 4,
  parameter int SILENCE_CYC  = 16384,
  parameter int ARM_CYC      = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int DUR_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             waveform,
  input  logic [2:0]       det_note,
  output logic             det_reset,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_note,
  output logic             evt_silence,
  output logic [DUR_W-1:0] evt_dur,
  output logic             overflow,
  output logic [2:0]       state_dbg
);
  localparam int TW = $clog2(SILENCE_CYC + 1);
  localparam int PW = $clog2(STABLE_EDGES + 1);
  localparam int AW = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int EW = 3 + 1 + DUR_W;

  localparam logic [TW-1:0]    TIMEOUT_P = TW'(SILENCE_CYC);
  localparam logic [PW-1:0]    STABLE_P  = PW'(STABLE_EDGES);
  localparam logic [AW-1:0]    ARM_LAST  = AW'(ARM_CYC - 1);
  localparam logic [DUR_W-1:0] STABLE_D  = DUR_W'(STABLE_EDGES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_LISTEN = 3'd2,
    S_TRACK  = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  state_t state, state_n;

  // Waveform synchroniser; wave_prev holds the previous synchronised value.
  logic wave_s1, wave_s2, wave_prev, wave_edge;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wave_s1   <= 1'b0;
      wave_s2   <= 1'b0;
      wave_prev <= 1'b0;
    end else begin
      wave_s1   <= waveform;
      wave_s2   <= wave_s1;
      wave_prev <= wave_s2;
    end
  end
  assign wave_edge = wave_s2 ^ wave_prev;

  // Silence timer: cycles since the last edge. It saturates at the timeout
  // value, so timeout stays asserted until the next edge arrives.
  logic [TW-1:0] timer;
  logic          timeout;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           timer <= '0;
    else if (wave_edge || state == S_ARM) timer <= '0;
    else if (timer != TIMEOUT_P)         timer <= timer + 1'b1;
  end
  assign timeout = (timer == TIMEOUT_P);

  // Controller registers
  logic [2:0]       cand, cand_n, cur, cur_n;
  logic [PW-1:0]    pc, pc_n;
  logic [DUR_W-1:0] cnt, cnt_n, cnt_inc, dur_sw;
  logic [AW-1:0]    arm_cnt, arm_n;
  logic             push, ovf_clr;
  logic [EW-1:0]    push_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cand    <= '0;
      cur     <= '0;
      pc      <= '0;
      cnt     <= '0;
      arm_cnt <= '0;
    end else begin
      state   <= state_n;
      cand    <= cand_n;
      cur     <= cur_n;
      pc      <= pc_n;
      cnt     <= cnt_n;
      arm_cnt <= arm_n;
    end
  end

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  // A note closed by a switch gets the edges before the new note's qualifying
  // run. Once the count saturates, the true length is unknown, so the
  // duration is reported as all-ones.
  assign dur_sw  = (cnt_inc == '1) ? '1 : cnt_inc - STABLE_D;

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cur_n     = cur;
    pc_n      = pc;
    cnt_n     = cnt;
    arm_n     = arm_cnt;
    push      = 1'b0;
    push_data = '0;
    ovf_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ARM;
          arm_n   = '0;
          ovf_clr = 1'b1;
        end
      end
      S_ARM: begin
        cand_n = '0;
        pc_n   = '0;
        cnt_n  = '0;
        if (stop)                     state_n = S_IDLE;
        else if (arm_cnt == ARM_LAST) state_n = S_LISTEN;
        else                          arm_n   = arm_cnt + 1'b1;
      end
      S_LISTEN: begin
        if (stop) begin
          state_n = S_IDLE;
        end else if (wave_edge) begin
          if (det_note == cand) begin
            pc_n = pc + 1'b1;
          end else begin
            cand_n = det_note;
            pc_n   = PW'(1);
          end
          if (pc_n == STABLE_P) begin
            state_n = S_TRACK;
            cur_n   = cand_n;
            cnt_n   = STABLE_D;
            pc_n    = '0;
          end
        end else if (timeout) begin
          cand_n = '0;
          pc_n   = '0;
        end
      end
      S_TRACK: begin
        if (stop) begin
          push      = 1'b1;
          push_data = {cur, 1'b0, cnt};
          state_n   = S_IDLE;
        end else if (timeout) begin
          push      = 1'b1;
          push_data = {cur, 1'b0, cnt};
          state_n   = S_FLUSH;
        end else if (wave_edge) begin
          cnt_n = cnt_inc;
          // pc counts the current run of a note that differs from cur;
          // any return to cur abandons that run.
          if (det_note == cur) begin
            pc_n = '0;
          end else if (det_note == cand && pc != '0) begin
            pc_n = pc + 1'b1;
          end else begin
            cand_n = det_note;
            pc_n   = PW'(1);
          end
          if (pc_n == STABLE_P) begin
            push      = 1'b1;
            push_data = {cur, 1'b0, dur_sw};
            cur_n     = cand_n;
            cnt_n     = STABLE_D;
            pc_n      = '0;
          end
        end
      end
      S_FLUSH: begin
        if (stop) begin
          state_n = S_IDLE;
        end else begin
          push      = 1'b1;
          push_data = {3'd0, 1'b1, {DUR_W{1'b0}}};
          state_n   = S_ARM;
          arm_n     = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Event FIFO: first-word-fall-through. The pointers carry one extra wrap
  // bit so the FIFO can tell full from empty.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [FW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, wr_en;
  logic [EW-1:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
  assign pop   = !empty && evt_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still succeeds when the consumer is reading.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[FW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (ovf_clr)              overflow <= 1'b0;
      else if (push && !wr_en)  overflow <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr[FW-1:0]];
  assign evt_valid = !empty;
  // Head fields read as zero while the FIFO is empty, so the outputs are
  // all zero after reset, even though the storage itself is never cleared.
  assign {evt_note, evt_silence, evt_dur} = evt_valid ? head : '0;

  assign det_reset = (state == S_ARM);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
